// File: rtl/branch_redirect_ctrl.sv
// Fetch-redirect sequencer: tracks unresolved predicted branches in order, checks
// BRU resolutions against the oldest one and drives redirect/stall into pc_generate.
module branch_redirect_ctrl #(
  parameter int DEPTH     = 4,
  parameter int RECOV_LAT = 2
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     pred_valid,
  input  logic                     pred_taken,
  input  logic [63:0]              pred_alt_pc,
  input  logic                     bru_res_valid,
  input  logic                     bru_taken,
  input  logic                     excp_valid,
  input  logic [63:0]              excp_pc,
  output logic                     redirect_valid,
  output logic [63:0]              redirect_pc,
  output logic                     redirect_cause,
  output logic                     fetch_stall,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err_overflow,
  output logic                     err_underflow,
  output logic [1:0]               state_dbg
);

  localparam int PW = $clog2(DEPTH);
  localparam int NW = PW + 1;
  localparam int CW = $clog2(RECOV_LAT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_RECOVER  = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  rcnt, rcnt_nxt;

  logic           q_taken [DEPTH];
  logic [63:0]    q_alt   [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [NW-1:0]  count;

  logic full, empty, in_run, push, pop, mispredict, excp_take, do_redirect;

  // pred_valid, bru_res_valid and excp_valid are strobes with no ready: a strobe
  // is consumed in the cycle it is seen in RUN, and ignored (not held) otherwise.
  assign full        = (count == NW'(DEPTH));
  assign empty       = (count == '0);
  assign in_run      = (state == ST_RUN);
  assign push        = in_run & pred_valid & ~full;
  assign pop         = in_run & bru_res_valid & ~empty;
  assign mispredict  = pop & (bru_taken != q_taken[rd_ptr]);
  assign excp_take   = in_run & excp_valid;
  assign do_redirect = mispredict | excp_take;

  assign outstanding = count;
  assign state_dbg   = state;

  always_ff @(posedge clk) begin
    if (RST) begin
      state <= ST_RUN;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rcnt_nxt    = rcnt;
    fetch_stall = 1'b1;
    case (state)
      ST_RUN: begin
        fetch_stall = full;
        if (do_redirect) state_nxt = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        rcnt_nxt  = CW'(RECOV_LAT);
        state_nxt = ST_RECOVER;
      end
      ST_RECOVER: begin
        rcnt_nxt = rcnt - CW'(1);
        if (rcnt == CW'(1)) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Queue storage carries no reset; occupancy is governed by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      q_taken[wr_ptr] <= pred_taken;
      q_alt[wr_ptr]   <= pred_alt_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      redirect_cause <= 1'b0;
      err_overflow   <= 1'b0;
      err_underflow  <= 1'b0;
    end else begin
      redirect_valid <= do_redirect;
      if (do_redirect) begin
        // Everything younger than the redirect is wrong-path, including a same-cycle push.
        redirect_pc    <= excp_take ? excp_pc : q_alt[rd_ptr];
        redirect_cause <= excp_take;
        rd_ptr         <= '0;
        wr_ptr         <= '0;
        count          <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + NW'(push) - NW'(pop);
      end
      if (in_run & pred_valid & full)     err_overflow  <= 1'b1;
      if (in_run & bru_res_valid & empty) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: a queue-based branch model predicts each redirect
// into a scoreboard and the expected occupancy, stall and error flags every cycle.
module tb_branch_redirect_ctrl;

  localparam int DEPTH     = 4;
  localparam int RECOV_LAT = 2;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        pred_valid = 1'b0, pred_taken = 1'b0;
  logic [63:0] pred_alt_pc = '0;
  logic        bru_res_valid = 1'b0, bru_taken = 1'b0;
  logic        excp_valid = 1'b0;
  logic [63:0] excp_pc = '0;
  logic        redirect_valid, redirect_cause, fetch_stall, err_overflow, err_underflow;
  logic [63:0] redirect_pc;
  logic [2:0]  outstanding;
  logic [1:0]  state_dbg;

  branch_redirect_ctrl #(.DEPTH(DEPTH), .RECOV_LAT(RECOV_LAT)) dut (
    .clk(clk), .RST(RST),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_alt_pc(pred_alt_pc),
    .bru_res_valid(bru_res_valid), .bru_taken(bru_taken),
    .excp_valid(excp_valid), .excp_pc(excp_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_cause(redirect_cause), .fetch_stall(fetch_stall),
    .outstanding(outstanding), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [64:0] exp_q[$];  // {cause, pc} of each redirect the model predicts
  logic [64:0] m_q[$];    // {taken, alt_pc} of outstanding branches
  logic [64:0] m_rpc = '0;
  int          m_busy = 0;
  bit          m_ovf = 0, m_unf = 0;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    pred_valid = 1'b0; bru_res_valid = 1'b0; excp_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_redirect_cause", redirect_cause, 0);
    check("rst_fetch_stall", fetch_stall, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_err_overflow", err_overflow, 0);
    check("rst_err_underflow", err_underflow, 0);
    check("rst_state", state_dbg, 0);
    RST = 1'b0;
    m_q.delete(); exp_q.delete();
    m_rpc = '0; m_busy = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic step(input logic pv, input logic pt, input logic [63:0] palt,
                      input logic bv, input logic bt, input logic ev, input logic [63:0] epc);
    bit          pend;
    bit          full, pop;
    logic [64:0] head, e;
    pend = 0;
    pred_valid = pv; pred_taken = pt; pred_alt_pc = palt;
    bru_res_valid = bv; bru_taken = bt; excp_valid = ev; excp_pc = epc;
    if (m_busy > 0) begin
      m_busy--;
    end else begin
      full = (m_q.size() == DEPTH);
      pop  = bv && (m_q.size() > 0);
      head = pop ? m_q[0] : '0;
      if (pv && full) m_ovf = 1;
      if (bv && m_q.size() == 0) m_unf = 1;
      if (ev) begin
        e = {1'b1, epc}; pend = 1;
      end else if (pop && (bt != head[64])) begin
        e = {1'b0, head[63:0]}; pend = 1;
      end
      if (pend) begin
        m_q.delete();
        m_busy = 1 + RECOV_LAT;
        m_rpc = e;
        exp_q.push_back(e);
      end else begin
        if (pop) void'(m_q.pop_front());
        if (pv && !full) m_q.push_back({pt, palt});
      end
    end
    @(posedge clk); #1;
    check("redirect_valid", redirect_valid, pend);
    if (redirect_valid) begin
      if (exp_q.size() == 0) check("redirect_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("redirect", {redirect_cause, redirect_pc}, e);
      end
    end
    check("redirect_hold", {redirect_cause, redirect_pc}, m_rpc);
    check("outstanding", outstanding, m_q.size());
    check("fetch_stall", fetch_stall, (m_busy > 0) || (m_q.size() == DEPTH));
    check("in_run", state_dbg == 2'd0, m_busy == 0);
    check("err_overflow", err_overflow, m_ovf);
    check("err_underflow", err_underflow, m_unf);
  endtask

  task automatic idle();
    step(0, 0, 64'h0, 0, 0, 0, 64'h0);
  endtask

  initial begin
    int stall_cycles;
    do_reset();

    // Fill to DEPTH, then one push too many.
    for (int i = 1; i <= 4; i++) step(1, 1, 64'(i * 'h100), 0, 0, 0, 64'h0);
    check("t1_outstanding_full", outstanding, 4);
    check("t1_stall_full", fetch_stall, 1);
    step(1, 1, 64'h500, 0, 0, 0, 64'h0);
    check("t1_overflow", err_overflow, 1);
    check("t1_outstanding_kept", outstanding, 4);
    do_reset();

    // Mispredict: redirect to alt PC, then stall for 1+RECOV_LAT cycles.
    step(1, 1, 64'h1000, 0, 0, 0, 64'h0);
    step(0, 0, 64'h0, 1, 0, 0, 64'h0);
    check("t2_pulse", redirect_valid, 1);
    check("t2_pc", redirect_pc, 64'h1000);
    check("t2_cause", redirect_cause, 0);
    check("t2_outstanding", outstanding, 0);
    stall_cycles = fetch_stall ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      idle();
      if (fetch_stall) stall_cycles++;
    end
    check("t2_stall_cycles", stall_cycles, 1 + RECOV_LAT);

    // Same-cycle push + resolution, correct then wrong.
    step(1, 1, 64'h10, 0, 0, 0, 64'h0);
    step(1, 0, 64'h20, 0, 0, 0, 64'h0);
    step(1, 1, 64'h50, 1, 1, 0, 64'h0);
    check("t3_correct_outstanding", outstanding, 2);
    check("t3_correct_no_redirect", redirect_valid, 0);
    step(1, 1, 64'h60, 1, 1, 0, 64'h0);
    check("t3_wrong_outstanding", outstanding, 0);
    check("t3_wrong_pc", redirect_pc, 64'h20);
    for (int i = 0; i < 3; i++) idle();
    check("t3_push_discarded", outstanding, 0);

    // Exception wins over a same-cycle mispredict.
    step(1, 1, 64'h70, 0, 0, 0, 64'h0);
    step(0, 0, 64'h0, 1, 0, 1, 64'h8000_0000);
    check("t4_pc", redirect_pc, 64'h8000_0000);
    check("t4_cause", redirect_cause, 1);
    idle();
    check("t4_single_pulse", redirect_valid, 0);
    for (int i = 0; i < 2; i++) idle();

    // Resolution with nothing outstanding.
    step(0, 0, 64'h0, 1, 0, 0, 64'h0);
    check("t5_underflow", err_underflow, 1);
    check("t5_no_redirect", redirect_valid, 0);
    check("t5_outstanding", outstanding, 0);

    // Reset while recovering.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 64'(i + 'h900), 0, 0, 0, 64'h0);
    step(0, 0, 64'h0, 0, 0, 1, 64'hABC0);
    idle();
    check("t6_in_recover", state_dbg, 2);
    do_reset();
    step(1, 1, 64'hD00, 0, 0, 0, 64'h0);
    check("t6_push_after_reset", outstanding, 1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 64'($urandom_range(1, 'hFFFF)) << 2,
           $urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)),
           $urandom_range(0, 19) == 0, 64'($urandom_range(1, 'hFFFF)) << 4);
    for (int i = 0; i < 4; i++) idle();

    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
